// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back with a memory ready handshake.
module mips_multicycle_control #(
   parameter int CNT_WIDTH = 32,
   parameter bit EN_ADDI   = 1'b1,
   parameter bit EN_BNE    = 1'b1,
   parameter bit MEM_WAIT  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           opcode,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 branch_ne,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 mem_to_reg,
   output logic                 reg_dst,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           pc_source,
   output logic [3:0]           state,
   output logic [CNT_WIDTH-1:0] retired,
   output logic                 illegal
);

   localparam logic [5:0] opR    = 6'h00;
   localparam logic [5:0] opJ    = 6'h02;
   localparam logic [5:0] opBeq  = 6'h04;
   localparam logic [5:0] opBne  = 6'h05;
   localparam logic [5:0] opAddi = 6'h08;
   localparam logic [5:0] opLw   = 6'h23;
   localparam logic [5:0] opSw   = 6'h2B;

   typedef enum logic [3:0] {
      Fetch    = 4'd0,
      Decode   = 4'd1,
      MemAddr  = 4'd2,
      MemRd    = 4'd3,
      MemWb    = 4'd4,
      MemWr    = 4'd5,
      Exec     = 4'd6,
      RWb      = 4'd7,
      Branch   = 4'd8,
      Jump     = 4'd9,
      AddiExec = 4'd10,
      AddiWb   = 4'd11,
      Trap     = 4'd12
   } stateT;

   stateT curState;
   stateT nextState;
   logic  rdy;
   logic  retire;

   assign rdy   = mem_ready | ~MEM_WAIT;
   assign state = curState;

   // State register; reset aborts any instruction immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) curState <= Fetch;
      else     curState <= nextState;
   end

   // Next-state logic.
   always_comb begin
      nextState = Fetch;
      case (curState)
         Fetch:    nextState = rdy ? Decode : Fetch;
         Decode: begin
            case (opcode)
               opLw, opSw: nextState = MemAddr;
               opR:        nextState = Exec;
               opBeq:      nextState = Branch;
               opBne:      nextState = EN_BNE ? Branch : Trap;
               opJ:        nextState = Jump;
               opAddi:     nextState = EN_ADDI ? AddiExec : Trap;
               default:    nextState = Trap;
            endcase
         end
         MemAddr:  nextState = (opcode == opLw) ? MemRd : MemWr;
         MemRd:    nextState = rdy ? MemWb : MemRd;
         MemWb:    nextState = Fetch;
         MemWr:    nextState = rdy ? Fetch : MemWr;
         Exec:     nextState = RWb;
         RWb:      nextState = Fetch;
         Branch:   nextState = Fetch;
         Jump:     nextState = Fetch;
         AddiExec: nextState = AddiWb;
         AddiWb:   nextState = Fetch;
         Trap:     nextState = Trap;
         default:  nextState = Fetch;
      endcase
   end

   // Moore outputs; everything held low while reset is asserted.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal       = 1'b0;
      if (!rst) begin
         case (curState)
            Fetch: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = rdy;
               pc_write  = rdy;
            end
            Decode:   alu_src_b = 2'b11;
            MemAddr: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MemRd: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            MemWb: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MemWr: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            Exec: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            RWb: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            Branch: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_source     = 2'b01;
               pc_write_cond = 1'b1;
               branch_ne     = (opcode == opBne);
            end
            Jump: begin
               pc_source = 2'b10;
               pc_write  = 1'b1;
            end
            AddiExec: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            AddiWb:   reg_write = 1'b1;
            Trap:     illegal = 1'b1;
            default:  illegal = 1'b0;
         endcase
      end
   end

   // An instruction retires on its final transition back to FETCH.
   always_comb begin
      retire = (nextState == Fetch) &&
               (curState inside {MemWb, MemWr, RWb, Branch, Jump, AddiWb});
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         retired <= '0;
      else if (retire) retired <= retired + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control.
// Two instances: default parameters (A) and a reduced build (B).
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic       mem_ready = 1'b1;

   logic pwA, pwcA, bneA, iodA, mrA, mwA, irwA, m2rA, rdA, rwA, asaA, illA;
   logic [1:0] asbA, aopA, psA;
   logic [3:0] stA;
   logic [31:0] retA;

   logic pwB, pwcB, bneB, iodB, mrB, mwB, irwB, m2rB, rdB, rwB, asaB, illB;
   logic [1:0] asbB, aopB, psB;
   logic [3:0] stB;
   logic [3:0] retB;

   logic [17:0] ctlA, ctlB;
   assign ctlA = {pwA, pwcA, bneA, iodA, mrA, mwA, irwA, m2rA, rdA, rwA,
                  asaA, asbA, aopA, psA, illA};
   assign ctlB = {pwB, pwcB, bneB, iodB, mrB, mwB, irwB, m2rB, rdB, rwB,
                  asaB, asbB, aopB, psB, illB};

   mips_multicycle_control dutA (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pwA), .pc_write_cond(pwcA), .branch_ne(bneA),
      .i_or_d(iodA), .mem_read(mrA), .mem_write(mwA), .ir_write(irwA),
      .mem_to_reg(m2rA), .reg_dst(rdA), .reg_write(rwA),
      .alu_src_a(asaA), .alu_src_b(asbA), .alu_op(aopA),
      .pc_source(psA), .state(stA), .retired(retA), .illegal(illA)
   );

   mips_multicycle_control #(
      .CNT_WIDTH(4), .EN_ADDI(1'b0), .EN_BNE(1'b0), .MEM_WAIT(1'b0)
   ) dutB (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pwB), .pc_write_cond(pwcB), .branch_ne(bneB),
      .i_or_d(iodB), .mem_read(mrB), .mem_write(mwB), .ir_write(irwB),
      .mem_to_reg(m2rB), .reg_dst(rdB), .reg_write(rwB),
      .alu_src_a(asaB), .alu_src_b(asbB), .alu_op(aopB),
      .pc_source(psB), .state(stB), .retired(retB), .illegal(illB)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        dut;
      logic [3:0]  st;
      logic [17:0] ctl;
      logic [31:0] ret;
   } expT;

   expT  sbq[$];
   int   errors = 0;
   int   checks = 0;
   logic curDut = 1'b0;
   event asyncProbe;

   // Expected control vector per state, written out from the state table.
   function automatic logic [17:0] expCtl(input logic [3:0] s, input logic rdy,
                                          input logic [5:0] opc);
      logic pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
      logic [1:0] asb, aop, ps;
      {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
      asb = 2'b00; aop = 2'b00; ps = 2'b00;
      case (s)
         4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
         4'd1:  asb = 2'b11;
         4'd2:  begin asa = 1; asb = 2'b10; end
         4'd3:  begin mr = 1; iod = 1; end
         4'd4:  begin rw = 1; m2r = 1; end
         4'd5:  begin mw = 1; iod = 1; end
         4'd6:  begin asa = 1; aop = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; end
         4'd8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pwc = 1;
                      bne = (opc == 6'h05); end
         4'd9:  begin ps = 2'b10; pw = 1; end
         4'd10: begin asa = 1; asb = 2'b10; end
         4'd11: rw = 1;
         4'd12: ill = 1;
         default: ill = 0;
      endcase
      return {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ill};
   endfunction

   // Drive one cycle of stimulus and queue the expected response.
   task automatic step(input string nm, input logic r, input logic [5:0] opc,
                       input logic rdy, input logic [3:0] es,
                       input logic [31:0] er);
      expT e;
      @(posedge clk);
      #1;
      rst = r;
      opcode = opc;
      mem_ready = rdy;
      e.name = nm;
      e.dut = curDut;
      e.st = es;
      e.ret = er;
      e.ctl = r ? 18'd0 : expCtl(es, curDut ? 1'b1 : rdy, opc);
      sbq.push_back(e);
   endtask

   // Monitor: compare the selected instance against the head of the queue.
   always begin
      expT e;
      logic [3:0]  aSt;
      logic [17:0] aCtl;
      logic [31:0] aRet;
      @(negedge clk or asyncProbe);
      #0;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         aSt  = e.dut ? stB : stA;
         aCtl = e.dut ? ctlB : ctlA;
         aRet = e.dut ? {28'd0, retB} : retA;
         checks++;
         if (aSt !== e.st || aCtl !== e.ctl || aRet !== e.ret) begin
            errors++;
            $display("FAIL %s dut%0d: got st=%0d ctl=%h ret=%0d, want st=%0d ctl=%h ret=%0d",
                     e.name, e.dut, aSt, aCtl, aRet, e.st, e.ctl, e.ret);
         end
      end
   end

   initial begin
      expT e;
      // Instance A: default build
      curDut = 1'b0;
      step("reset", 1, 6'h00, 1, 0, 0);
      step("reset", 1, 6'h00, 1, 0, 0);
      step("rtype", 0, 6'h00, 1, 0, 0);
      step("rtype", 0, 6'h00, 1, 1, 0);
      step("rtype", 0, 6'h00, 1, 6, 0);
      step("rtype", 0, 6'h00, 1, 7, 0);
      step("lw",    0, 6'h23, 1, 0, 1);
      step("lw",    0, 6'h23, 1, 1, 1);
      step("lw",    0, 6'h23, 1, 2, 1);
      step("lw",    0, 6'h23, 0, 3, 1);
      step("lw",    0, 6'h23, 0, 3, 1);
      step("lw",    0, 6'h23, 1, 3, 1);
      step("lw",    0, 6'h23, 1, 4, 1);
      step("sw",    0, 6'h2B, 0, 0, 2);
      step("sw",    0, 6'h2B, 1, 0, 2);
      step("sw",    0, 6'h2B, 1, 1, 2);
      step("sw",    0, 6'h2B, 1, 2, 2);
      step("sw",    0, 6'h2B, 1, 5, 2);
      step("addi",  0, 6'h08, 1, 0, 3);
      step("addi",  0, 6'h08, 1, 1, 3);
      step("addi",  0, 6'h08, 1, 10, 3);
      step("addi",  0, 6'h08, 1, 11, 3);
      step("beq",   0, 6'h04, 1, 0, 4);
      step("beq",   0, 6'h04, 1, 1, 4);
      step("beq",   0, 6'h04, 1, 8, 4);
      step("bne",   0, 6'h05, 1, 0, 5);
      step("bne",   0, 6'h05, 1, 1, 5);
      step("bne",   0, 6'h05, 1, 8, 5);
      step("j",     0, 6'h02, 1, 0, 6);
      step("j",     0, 6'h02, 1, 1, 6);
      step("j",     0, 6'h02, 1, 9, 6);
      step("ill",   0, 6'h3F, 1, 0, 7);
      step("ill",   0, 6'h3F, 1, 1, 7);
      step("ill",   0, 6'h3F, 1, 12, 7);
      step("trap",  0, 6'h00, 1, 12, 7);
      step("trap",  0, 6'h00, 1, 12, 7);
      step("trprst", 1, 6'h00, 1, 0, 0);
      step("trprst", 1, 6'h00, 1, 0, 0);
      step("swasync", 0, 6'h2B, 1, 0, 0);
      step("swasync", 0, 6'h2B, 1, 1, 0);
      step("swasync", 0, 6'h2B, 1, 2, 0);
      step("swasync", 0, 6'h2B, 0, 5, 0);
      // Reset mid-cycle, away from any clock edge
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      e.name = "asyncrst"; e.dut = 1'b0; e.st = 4'd0;
      e.ctl = 18'd0; e.ret = 32'd0;
      sbq.push_back(e);
      ->asyncProbe;

      // Instance B: no addi/bne, no memory wait, 4-bit counter
      curDut = 1'b1;
      step("resetB", 1, 6'h00, 0, 0, 0);
      step("resetB", 1, 6'h00, 0, 0, 0);
      step("swB",   0, 6'h2B, 0, 0, 0);
      step("swB",   0, 6'h2B, 0, 1, 0);
      step("swB",   0, 6'h2B, 0, 2, 0);
      step("swB",   0, 6'h2B, 0, 5, 0);
      step("bneB",  0, 6'h05, 0, 0, 1);
      step("bneB",  0, 6'h05, 0, 1, 1);
      step("bneB",  0, 6'h05, 0, 12, 1);
      step("bneB",  0, 6'h05, 0, 12, 1);
      step("rstB",  1, 6'h02, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step("jB", 0, 6'h02, 0, 0, i);
         step("jB", 0, 6'h02, 0, 1, i);
         step("jB", 0, 6'h02, 0, 9, i);
      end
      step("wrapB", 0, 6'h08, 0, 0, 0);
      step("addiB", 0, 6'h08, 0, 1, 0);
      step("addiB", 0, 6'h08, 0, 12, 0);

      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Moore-style control FSM for the multi-cycle MIPS datapath, the successor to the single-cycle core's combinational control unit. Sequences each instruction through fetch, decode, execute, memory and write-back states, driving the shared ALU, memory and register-file selects. Memory accesses use a ready handshake, so variable-latency memory is supported. Optional instruction classes (addi, bne) are enabled by parameter. A retired-instruction counter and an illegal-opcode trap are included.

## Interface
- `CNT_WIDTH`, 32: width of the retired-instruction counter.
- `EN_ADDI`, 1: when 1, opcode 0x08 (addi) is legal.
- `EN_BNE`, 1: when 1, opcode 0x05 (bne) is legal.
- `MEM_WAIT`, 1: when 1, memory states wait on `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: instruction[31:26] from the instruction register. It is stable from the cycle after an IR load.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load qualified by the datapath branch compare.
- `branch_ne` out 1: when 1, the datapath branch compare is `!zero`. When 0, it is `zero`.
- `i_or_d` out 1: memory address select. 0 selects PC; 1 selects ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: write-back data select. 0 selects ALUOut; 1 selects MDR.
- `reg_dst` out 1: destination register select. 0 selects rt; 1 selects rd.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select. 0 selects PC; 1 selects register A.
- `alu_src_b` out 2: ALU B select. 00 selects B; 01 selects 4; 10 selects sign-extended imm; 11 selects sign-extended imm shifted left 2.
- `alu_op` out 2: to ALUControl. 00 is add; 01 is sub; 10 selects by funct.
- `pc_source` out 2: PC mux select. 00 selects ALU result; 01 selects ALUOut; 10 selects jump target.
- `state` out 4: current state encoding, for debug.
- `retired` out CNT_WIDTH: count of completed instructions.
- `illegal` out 1: high while in TRAP.

## Operation
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=12. Codes 13–15 go to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, ir_write=pc_write=rdy. Here rdy means (mem_ready | !MEM_WAIT).
  - Transition: stay while !rdy; otherwise go to DECODE.
- DECODE:
  - Outputs: alu_src_b=11, used to precompute the branch target.
  - Transitions by opcode:
    - 0x23 or 0x2B → MEM_ADDR.
    - 0x00 → EXEC.
    - 0x04 → BRANCH.
    - 0x05 → BRANCH if EN_BNE.
    - 0x02 → JUMP.
    - 0x08 → ADDI_EXEC if EN_ADDI.
    - Anything else → TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Next: 0x23 → MEM_RD; 0x2B → MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Stay while !rdy; otherwise go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Stay while !rdy; otherwise go to FETCH.
- EXEC: alu_src_a=1, alu_op=10. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1. Next: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1, branch_ne=(opcode==0x05).
  - Next: FETCH.
- JUMP: pc_source=10, pc_write=1. Next: FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. Next: FETCH.
- TRAP: illegal=1. All strobes are 0. TRAP is absorbing; only `rst` leaves it.
- Retirement: `retired` increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^CNT_WIDTH. A branch counts whether or not it is taken.

## Timing
- Reset: while `rst`=1, state=FETCH, retired=0, illegal=0, and all control outputs are forced to 0. This gating applies even to FETCH strobes.
- First fetch: the first fetch strobe appears in the first cycle after `rst` falls.
- Reset mid-instruction: aborts immediately (asynchronous), with no write strobe after assertion.
- Outputs are a function of state only, except the rdy-gated ir_write/pc_write in FETCH.
- Cycles per instruction with rdy=1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each wait cycle adds 1 to the count. During a wait, strobes and selects are held constant.
- `mem_ready` is sampled only in FETCH, MEM_RD and MEM_WR. In other states it is ignored.
- When an address-phase `mem_ready` arrives, it is not remembered.

## Test plan
- Reset, then R-type (opcode 0x00) with mem_ready=1 → states 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7. retired=1 after 4 cycles.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD → sequence 0,1,2,3,3,3,4,0. mem_read and i_or_d are held for 3 cycles. Total 7 cycles.
- bne (0x05) with EN_BNE=1 → BRANCH with branch_ne=1 and pc_write_cond=1. With EN_BNE=0 → TRAP, illegal=1, held until `rst`.
- Illegal opcode 0x3F → TRAP. `rst` pulse mid-TRAP → state=0, retired=0, all strobes 0 during reset.
- MEM_WAIT=0 with mem_ready tied to 0 → sw completes in 4 cycles. 2^CNT_WIDTH retirements (CNT_WIDTH=4, 16 jumps) → retired wraps to 0.
- Async reset asserted mid-cycle in MEM_WR → mem_write drops without a clock edge, and state=0.
